// File: rtl/core_irq_pkg.sv
// Shared definitions for the core interrupt path: arbiter state encoding,
// interrupt-number width and the maximum number of external lines.
package core_irq_pkg;

   localparam int IRQ_NUM_W     = 6;
   localparam int IRQ_MAX_LINES = 64;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'h0,
      ST_PRESENT = 2'h1,
      ST_GAP     = 2'h2
   } arb_state_e;

   function automatic logic [IRQ_MAX_LINES-1:0] irq_onehot(input logic [IRQ_NUM_W-1:0] n);
      return IRQ_MAX_LINES'(1) << n;
   endfunction

endpackage

// File: rtl/core_irq_prio_enc.sv
// Find-first-set over a 64-bit vector, searching upward from a rotate base
// and wrapping at 64. A base of zero gives plain lowest-index priority.
module core_irq_prio_enc
   import core_irq_pkg::*;
(
   input  logic [IRQ_MAX_LINES-1:0] vec_i,
   input  logic [IRQ_NUM_W-1:0]     base_i,
   output logic                     found_o,
   output logic [IRQ_NUM_W-1:0]     idx_o
);

   logic [IRQ_NUM_W-1:0] pos;

   // Walk from the far end back toward the base so the last hit is the nearest.
   always_comb begin
      found_o = 1'b0;
      idx_o   = '0;
      pos     = '0;
      for (int i = IRQ_MAX_LINES-1; i >= 0; i--) begin
         pos = base_i + IRQ_NUM_W'(i);
         if (vec_i[pos]) begin
            found_o = 1'b1;
            idx_o   = pos;
         end
      end
   end

endmodule

// File: rtl/core_ext_irq_arbiter.sv
// External interrupt arbiter: synchronise, edge-detect into pending, present one
// request at a time to the interrupt manager. CORE_EXT_IRQ_ROUNDROBIN_EN selects round-robin.
module core_ext_irq_arbiter
   import core_irq_pkg::*;
#(
   parameter int P_IRQ_LINES   = 64,
   parameter int P_SYNC_STAGES = 2
) (
   input  logic                     iCLOCK,
   input  logic                     inRESET,
   input  logic [P_IRQ_LINES-1:0]   iIRQ_REQ,
   input  logic                     iIRQ_CLEAR,
   output logic                     oEXT_ACTIVE,
   output logic [IRQ_NUM_W-1:0]     oEXT_NUM,
   input  logic                     iEXT_ACK,
   output logic [IRQ_MAX_LINES-1:0] oPENDING,
   output logic                     oBUSY
);

   localparam int ARM_MAX = P_SYNC_STAGES + 1;
   localparam int ARM_W   = $clog2(ARM_MAX + 1);

   logic [P_SYNC_STAGES-1:0][P_IRQ_LINES-1:0] sync_q;
   logic [P_IRQ_LINES-1:0]   hist_q;
   logic [P_IRQ_LINES-1:0]   rise;
   logic [P_IRQ_LINES-1:0]   pend_q, pend_d;
   logic [P_IRQ_LINES-1:0]   ack_mask;
   logic [IRQ_MAX_LINES-1:0] ack_onehot;
   logic [IRQ_MAX_LINES-1:0] pend_ext;
   logic [ARM_W-1:0]         arm_q;
   logic                     armed;

   arb_state_e           state_q, state_d;
   logic                 act_q, act_d;
   logic [IRQ_NUM_W-1:0] num_q, num_d;
   logic                 busy_q, busy_d;
   logic [IRQ_NUM_W-1:0] base;
   logic                 win_found;
   logic [IRQ_NUM_W-1:0] win_idx;

   // Lines already high as reset releases are levels, not edges: rise detection
   // stays masked until the synchroniser and history flops hold real samples.
   always_ff @(posedge iCLOCK or negedge inRESET) begin
      if (!inRESET) begin
         sync_q <= '0;
         hist_q <= '0;
         arm_q  <= '0;
      end else begin
         sync_q <= {sync_q[P_SYNC_STAGES-2:0], iIRQ_REQ};
         hist_q <= sync_q[P_SYNC_STAGES-1];
         if (!armed) arm_q <= arm_q + 1'b1;
      end
   end

   assign armed = (arm_q == ARM_W'(ARM_MAX));
   assign rise  = sync_q[P_SYNC_STAGES-1] & ~hist_q & {P_IRQ_LINES{armed}};

   always_comb begin
      pend_ext                  = '0;
      pend_ext[P_IRQ_LINES-1:0] = pend_q;
   end

   assign ack_onehot = irq_onehot(num_q);
   assign ack_mask   = ack_onehot[P_IRQ_LINES-1:0];

`ifdef CORE_EXT_IRQ_ROUNDROBIN_EN
   logic [IRQ_NUM_W-1:0] last_q;

   always_ff @(posedge iCLOCK or negedge inRESET) begin
      if (!inRESET)                             last_q <= '0;
      else if (state_q == ST_PRESENT && iEXT_ACK) last_q <= num_q;
   end

   // Upper indices are never pending, so wrapping at 64 equals wrapping at P_IRQ_LINES.
   always_comb begin
      if (32'(last_q) + 1 >= P_IRQ_LINES) base = '0;
      else                                base = last_q + 1'b1;
   end
`else
   assign base = '0;
`endif

   core_irq_prio_enc u_enc (
      .vec_i   (pend_ext),
      .base_i  (base),
      .found_o (win_found),
      .idx_o   (win_idx)
   );

   always_comb begin
      state_d = state_q;
      act_d   = act_q;
      num_d   = num_q;
      pend_d  = pend_q | rise;
      case (state_q)
         ST_IDLE: begin
            act_d = 1'b0;
            if (win_found && !iIRQ_CLEAR) begin
               num_d   = win_idx;
               act_d   = 1'b1;
               state_d = ST_PRESENT;
            end
         end
         ST_PRESENT: begin
            // A rise landing in the ack cycle re-arms the same line.
            if (iEXT_ACK) begin
               pend_d  = (pend_q & ~ack_mask) | rise;
               act_d   = 1'b0;
               state_d = ST_GAP;
            end else if (iIRQ_CLEAR) begin
               act_d   = 1'b0;
               state_d = ST_GAP;
            end
         end
         ST_GAP: begin
            act_d   = 1'b0;
            state_d = ST_IDLE;
         end
         default: begin
            act_d   = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
      if (iIRQ_CLEAR) pend_d = '0;
      busy_d = (state_d != ST_IDLE) || (pend_d != '0);
   end

   always_ff @(posedge iCLOCK or negedge inRESET) begin
      if (!inRESET) begin
         state_q <= ST_IDLE;
         act_q   <= 1'b0;
         num_q   <= '0;
         pend_q  <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         act_q   <= act_d;
         num_q   <= num_d;
         pend_q  <= pend_d;
         busy_q  <= busy_d;
      end
   end

   assign oEXT_ACTIVE = act_q;
   assign oEXT_NUM    = num_q;
   assign oPENDING    = pend_ext;
   assign oBUSY       = busy_q;

endmodule

// File: doc/core_ext_irq_arbiter.md
Name: core_ext_irq_arbiter

Overview:
- Upstream neighbour of the core interrupt manager.
- Collects up to 64 asynchronous external interrupt request lines, synchronises them and edge-detects them into a pending register.
- Arbitrates among pending requests and presents one request at a time on the manager's external interface (oEXT_ACTIVE/oEXT_NUM), holding it until the manager pulses its external-ack.
- Guarantees the manager sees a stable, single-source request and never a double delivery.

Parameters:
- P_IRQ_LINES, 64, number of request lines implemented (1..64); unused upper indices read as never-pending.
- P_SYNC_STAGES, 2, synchroniser depth per line (>=2).

Ports:
- iCLOCK  input  1  core clock
- inRESET  input  1  reset; asynchronous, active-low
- iIRQ_REQ  input  P_IRQ_LINES  raw external request lines, asynchronous, rising-edge significant
- iIRQ_CLEAR  input  1  synchronous flush of all pending bits (used only while the core is quiesced)
- oEXT_ACTIVE  output  1  request presented to the interrupt manager
- oEXT_NUM  output  6  index of the presented request
- iEXT_ACK  input  1  one-cycle acceptance pulse from the interrupt manager
- oPENDING  output  64  pending bitmap for debug/sysreg readout (zero-extended)
- oBUSY  output  1  high when state != IDLE or any pending bit is set

Behaviour:
- Reset (async, inRESET low):
  - all synchroniser flops, edge-history flops and pending bits = 0
  - state = IDLE, oEXT_ACTIVE = 0, oEXT_NUM = 0, oBUSY = 0
  - reset mid-presentation drops the request immediately; no ack is expected afterwards.
- Synchronise: each line passes through P_SYNC_STAGES flops; one extra history flop per line.
- Edge detect: rise = sync_out & ~history. A rise sets pending[i] at the next edge.
- Latency: a line first sampled high at posedge N sets pending at N+P_SYNC_STAGES. For an idle arbiter, oEXT_ACTIVE goes high after posedge N+P_SYNC_STAGES+1 (N+3 with default parameters).
- Level held high after an edge produces no further events. A new event needs a low of at least one synchronised cycle.
- States (2-bit):
  - IDLE: if any pending bit is set, select the winner, register oEXT_NUM = winner and oEXT_ACTIVE = 1, then go to PRESENT.
  - PRESENT: hold oEXT_ACTIVE and oEXT_NUM stable. On iEXT_ACK, clear pending[oEXT_NUM], set oEXT_ACTIVE = 0, go to GAP.
  - GAP: exactly one cycle with oEXT_ACTIVE = 0, so the manager's hardware-IRQ latch can release. Then go to IDLE.
  - Illegal encoding: go to IDLE with oEXT_ACTIVE = 0.
- Arbitration (default): fixed priority, lowest index wins. Selection is evaluated only in IDLE; the winner does not change while in PRESENT.
- Simultaneous events:
  - Rise on line k in the same cycle that ack clears pending[k]: pending[k] ends set. The new event wins and is delivered again later.
  - iIRQ_CLEAR and a rise in the same cycle: clear wins.
  - iIRQ_CLEAR in PRESENT without ack: all pending bits cleared, oEXT_ACTIVE = 0 next cycle, go to GAP.
  - iIRQ_CLEAR and ack in the same cycle: ack is honoured, all bits are cleared, go to GAP.
- iEXT_ACK in IDLE or GAP is ignored.
- All outputs are registered; oPENDING and oBUSY are updated every cycle.

Optional Feature:
- Macro: CORE_EXT_IRQ_ROUNDROBIN_EN.
- Defined: round-robin arbitration.
  - A 6-bit last-grant register (reset 0) is updated on each accepted ack.
  - The search in IDLE starts at last_grant+1, wraps modulo P_IRQ_LINES, and ends at last_grant.
- Undefined: fixed lowest-index priority; no last-grant register is synthesised.

Decomposition:
- Shared package core_irq_pkg:
  - state encodings IDLE = 2'h0, PRESENT = 2'h1, GAP = 2'h2
  - IRQ number width = 6
  - maximum line count = 64
- Sub-module core_irq_prio_enc: combinational find-first-set over a 64-bit vector with a 6-bit rotate base (base tied to 0 in fixed mode). Outputs found and index.

Test Plan:
- Single edge: pulse iIRQ_REQ[5] high for 3 cycles starting before posedge 10 -> oEXT_ACTIVE = 1 and oEXT_NUM = 5 after posedge 13, held until the ack pulse; low during GAP; pending[5] = 0; oBUSY = 0 two cycles after the ack.
- Fixed priority: rises on lines 9, 3 and 40 in the same cycle -> delivery order 3, 9, 40, each separated by a GAP cycle. Round-robin build with last_grant = 3 and lines 3 and 9 pending -> 9 delivered before 3.
- Re-arm during ack: line 7 presented; new rise on line 7 lands in the ack cycle -> line 7 delivered a second time after GAP.
- Level hold: line 2 held high for 50 cycles -> exactly one delivery; drop low 1 cycle then high -> a second delivery.
- Flush: lines 1 and 4 pending, line 1 in PRESENT; assert iIRQ_CLEAR with no ack -> oEXT_ACTIVE = 0 next cycle, oPENDING = 0, no further delivery.
- Async reset: drop inRESET while PRESENT on line 12 -> outputs go to 0 immediately. After release, with the line held high and no new edge -> no delivery.
